// File: rtl/ws281x_stream_transmitter.sv
// ws281x_stream_transmitter: streaming WS281x/SK6812 pixel serializer with one-deep holding buffer and automatic latch.
// Ports:
//   clkIN        system clock, rising edge
//   nResetIN     asynchronous active-low reset
//   dataIN       pixel word, MSB sent first
//   validIN      dataIN/lastIN valid
//   lastIN       pixel ends the frame
//   readyOUT     holding buffer empty (transfer on validIN && readyOUT)
//   busyOUT      transmitter not idle
//   underrunOUT  one-cycle pulse when a frame ends because the buffer ran dry
//   txOUT        serial line to the strip
module ws281x_stream_transmitter #(
    parameter int CLOCK_SPEED    = 50_000_000,
    parameter int BITS_PER_PIXEL = 24,
    parameter int T0H_NS         = 500,
    parameter int T1H_NS         = 1200,
    parameter int TBIT_NS        = 2500,
    parameter int TRESET_NS      = 50000
) (
    input  logic                      clkIN,
    input  logic                      nResetIN,
    input  logic [BITS_PER_PIXEL-1:0] dataIN,
    input  logic                      validIN,
    input  logic                      lastIN,
    output logic                      readyOUT,
    output logic                      busyOUT,
    output logic                      underrunOUT,
    output logic                      txOUT
);
    localparam longint NS_PER_S   = 1_000_000_000;
    localparam int     T0H_CYC    = int'(longint'(CLOCK_SPEED) * longint'(T0H_NS) / NS_PER_S);
    localparam int     T1H_CYC    = int'(longint'(CLOCK_SPEED) * longint'(T1H_NS) / NS_PER_S);
    localparam int     TBIT_CYC   = int'(longint'(CLOCK_SPEED) * longint'(TBIT_NS) / NS_PER_S);
    localparam int     TRESET_CYC = int'(longint'(CLOCK_SPEED) * longint'(TRESET_NS) / NS_PER_S);
    localparam int     BCW        = $clog2(TBIT_CYC);
    localparam int     LCW        = $clog2(TRESET_CYC + 1);
    localparam int     ICW        = $clog2(BITS_PER_PIXEL + 1);

    if (T0H_CYC < 1 || T0H_CYC >= T1H_CYC || T1H_CYC >= TBIT_CYC || TRESET_CYC < 1
        || BITS_PER_PIXEL < 8 || BITS_PER_PIXEL > 32) begin : g_bad_params
        $error("ws281x_stream_transmitter: illegal timing or pixel width parameters");
    end

    typedef enum logic [1:0] {IDLE, BIT, LATCH} state_t;

    state_t                    state_q, state_d;
    logic [BITS_PER_PIXEL-1:0] buf_data_q, shift_q, shift_d;
    logic                      buf_full_q, buf_last_q, last_q, last_d;
    logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [LCW-1:0]            lat_cnt_q, lat_cnt_d;
    logic [ICW-1:0]            idx_q, idx_d;
    logic                      tx_q, tx_d, underrun_q, underrun_d;
    logic                      take, draw, bit_end;
    logic [31:0]               thigh;

    assign take        = validIN & ~buf_full_q;
    assign readyOUT    = ~buf_full_q;
    assign busyOUT     = state_q != IDLE;
    assign underrunOUT = underrun_q;
    assign txOUT       = tx_q;

    // txOUT is registered, so the level is computed from the counter value of the next cycle.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        last_d     = last_q;
        bit_cnt_d  = bit_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        idx_d      = idx_q;
        tx_d       = 1'b0;
        underrun_d = 1'b0;
        draw       = 1'b0;
        bit_end    = bit_cnt_q == BCW'(TBIT_CYC - 1);
        thigh      = shift_q[BITS_PER_PIXEL-1] ? 32'(T1H_CYC) : 32'(T0H_CYC);
        case (state_q)
            IDLE: draw = buf_full_q;
            BIT: begin
                if (!bit_end) begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    tx_d      = 32'(bit_cnt_d) < thigh;
                end else if (idx_q != '0) begin
                    bit_cnt_d = '0;
                    idx_d     = idx_q - ICW'(1);
                    shift_d   = shift_q << 1;
                    tx_d      = 1'b1;
                end else if (!last_q && buf_full_q) begin
                    draw = 1'b1;
                end else begin
                    state_d    = LATCH;
                    lat_cnt_d  = '0;
                    underrun_d = ~last_q;
                end
            end
            LATCH: begin
                lat_cnt_d = lat_cnt_q + LCW'(1);
                if (lat_cnt_q == LCW'(TRESET_CYC - 1)) begin
                    state_d   = IDLE;
                    lat_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Loading from the buffer starts a pixel whose first bit begins high.
        if (draw) begin
            state_d   = BIT;
            shift_d   = buf_data_q;
            last_d    = buf_last_q;
            idx_d     = ICW'(BITS_PER_PIXEL - 1);
            bit_cnt_d = '0;
            tx_d      = 1'b1;
        end
    end

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            last_q     <= 1'b0;
            bit_cnt_q  <= '0;
            lat_cnt_q  <= '0;
            idx_q      <= '0;
            tx_q       <= 1'b0;
            underrun_q <= 1'b0;
            buf_data_q <= '0;
            buf_last_q <= 1'b0;
            buf_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            bit_cnt_q  <= bit_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            underrun_q <= underrun_d;
            if (take) begin
                buf_data_q <= dataIN;
                buf_last_q <= lastIN;
            end
            buf_full_q <= take | (buf_full_q & ~draw);
        end
    end
endmodule

// File: tb/tb_ws281x_stream_transmitter.sv
// tb_ws281x_stream_transmitter: self-checking bench for the WS281x stream transmitter (24- and 32-bit instances).
module tb_ws281x_stream_transmitter;
    localparam int TB = 125, T0 = 25, T1 = 60, TR = 2500;
    localparam int NEWF = TB + TR + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] data = '0;
    logic        valid = 1'b0, last = 1'b0, sel = 1'b0;
    logic        r24, b24, u24, t24, r32, b32, u32, t32;
    logic        rdy, busy, und, tx;

    always #5 clk = ~clk;

    ws281x_stream_transmitter dut24 (
        .clkIN(clk), .nResetIN(rst_n), .dataIN(data[23:0]), .validIN(valid & ~sel), .lastIN(last),
        .readyOUT(r24), .busyOUT(b24), .underrunOUT(u24), .txOUT(t24)
    );

    ws281x_stream_transmitter #(.BITS_PER_PIXEL(32)) dut32 (
        .clkIN(clk), .nResetIN(rst_n), .dataIN(data), .validIN(valid & sel), .lastIN(last),
        .readyOUT(r32), .busyOUT(b32), .underrunOUT(u32), .txOUT(t32)
    );

    assign rdy  = sel ? r32 : r24;
    assign busy = sel ? b32 : b24;
    assign und  = sel ? u32 : u24;
    assign tx   = sel ? t32 : t24;

    int   cyc = 0;
    int   total = 0, bad = 0;
    int   rises[$], falls[$], unds[$], bfalls[$];
    bit   exp_bits[$];
    int   gap_exp[$];
    logic ptx = 1'b0, pbusy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: cycle stamps of tx edges, underrun pulses and busy falls.
    always @(negedge clk) begin
        if (tx && !ptx) rises.push_back(cyc);
        if (!tx && ptx) falls.push_back(cyc);
        if (und) unds.push_back(cyc);
        if (!busy && pbusy) bfalls.push_back(cyc);
        ptx   <= tx;
        pbusy <= busy;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -99999;
    endfunction

    task automatic clear();
        rises.delete(); falls.delete(); unds.delete(); bfalls.delete();
        exp_bits.delete(); gap_exp.delete();
    endtask

    // Reference model: each pixel contributes its bits MSB first, rises spaced one bit period apart.
    task automatic add_pixel(input logic [31:0] d, input int w);
        for (int b = w - 1; b >= 0; b--) begin
            exp_bits.push_back(d[b]);
            gap_exp.push_back(TB);
        end
    endtask

    task automatic set_gap(input int v);
        gap_exp[gap_exp.size() - 1] = v;
    endtask

    // Called on a falling edge; returns on the falling edge after the accepting rising edge.
    task automatic push(input logic [31:0] d, input logic l, output int acc);
        data = d; last = l; valid = 1'b1; acc = -1;
        for (int k = 0; k < 20000 && acc < 0; k++) begin
            if (rdy) begin
                @(negedge clk);
                acc = cyc;
            end else @(negedge clk);
        end
        check("push_timeout", acc >= 0, 1);
    endtask

    task automatic wait_done();
        logic done = 1'b0;
        for (int k = 0; k < 40000 && !done; k++) begin
            @(negedge clk);
            done = !busy && rdy;
        end
        @(negedge clk);
        check("done_timeout", done, 1);
    endtask

    task automatic analyze(input string p);
        check({p, ".nrise"}, rises.size(), exp_bits.size());
        check({p, ".nfall"}, falls.size(), rises.size());
        for (int i = 0; i < rises.size() && i < falls.size() && i < exp_bits.size(); i++)
            check({p, ".high"}, falls[i] - rises[i], exp_bits[i] ? T1 : T0);
        for (int i = 0; i + 1 < rises.size() && i < gap_exp.size(); i++)
            if (gap_exp[i] > 0) check({p, ".period"}, rises[i + 1] - rises[i], gap_exp[i]);
    endtask

    initial begin
        int a0, a1, a2, r0, n1, n2, ns;
        logic [31:0] d;
        #1 rst_n = 1'b0;
        #1;
        check("rst.tx", tx, 0);
        check("rst.busy", busy, 0);
        check("rst.ready", rdy, 1);
        check("rst.underrun", und, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single pixel, last
        clear();
        push(32'hA50000, 1'b1, a0);
        valid = 1'b0;
        wait_done();
        add_pixel(32'hA50000, 24); set_gap(-1);
        analyze("s1");
        r0 = qat(rises, 0);
        check("s1.latency", r0 - a0, 1);
        check("s1.busyfall", qat(bfalls, 0) - r0, 24 * TB + TR);
        check("s1.nunder", unds.size(), 0);

        // three pixels streamed back to back
        clear();
        push(32'hFFFFFF, 1'b0, a0);
        push(32'h000000, 1'b0, a1);
        push(32'h0F0F0F, 1'b1, a2);
        valid = 1'b0;
        wait_done();
        add_pixel(32'hFFFFFF, 24); add_pixel(32'h000000, 24); add_pixel(32'h0F0F0F, 24); set_gap(-1);
        analyze("s2");
        r0 = qat(rises, 0);
        check("s2.refill1", a1 - a0, 2);
        check("s2.refill2", a2 - qat(rises, 24), 1);
        check("s2.nunder", unds.size(), 0);
        check("s2.busyfall", qat(bfalls, 0) - r0, 72 * TB + TR);

        // underrun: second pixel arrives 4000 cycles late
        clear();
        push(32'h123456, 1'b0, a0);
        valid = 1'b0;
        repeat (4000) @(negedge clk);
        push(32'hC0FFEE, 1'b1, a1);
        valid = 1'b0;
        wait_done();
        add_pixel(32'h123456, 24); set_gap(NEWF); add_pixel(32'hC0FFEE, 24); set_gap(-1);
        analyze("s3");
        r0 = qat(rises, 0);
        check("s3.nunder", unds.size(), 1);
        check("s3.under_at", qat(unds, 0) - r0, 24 * TB);
        check("s3.busyfall", qat(bfalls, 0) - r0, 24 * TB + TR);

        // reset in the middle of a frame with the buffer full
        clear();
        push(32'h5A5A5A, 1'b1, a0);
        push(32'h333333, 1'b1, a1);
        valid = 1'b0;
        r0 = qat(rises, 0);
        check("s4.ready_low", rdy, 0);
        for (int k = 0; k < 3000 && cyc < r0 + 1000; k++) @(negedge clk);
        check("s4.tx_pre", tx, 1);
        rst_n = 1'b0;
        #1;
        check("s4.tx", tx, 0);
        check("s4.busy", busy, 0);
        check("s4.ready", rdy, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear();
        d = $urandom & 32'hFFFFFF;
        push(d, 1'b1, a0);
        valid = 1'b0;
        wait_done();
        add_pixel(d, 24); set_gap(-1);
        analyze("s4");
        r0 = qat(rises, 0);
        check("s4.latency", r0 - a0, 1);
        check("s4.busyfall", qat(bfalls, 0) - r0, 24 * TB + TR);

        // 32-bit pixels
        sel = 1'b1;
        repeat (2) @(negedge clk);
        clear();
        push(32'h80000001, 1'b1, a0);
        valid = 1'b0;
        wait_done();
        add_pixel(32'h80000001, 32); set_gap(-1);
        analyze("s5");
        r0 = qat(rises, 0);
        check("s5.latency", r0 - a0, 1);
        check("s5.span", qat(rises, 31) + TB - r0, 32 * TB);
        check("s5.busyfall", qat(bfalls, 0) - r0, 32 * TB + TR);
        sel = 1'b0;
        repeat (2) @(negedge clk);

        // random two-frame stream
        clear();
        n1 = $urandom_range(1, 2);
        n2 = $urandom_range(1, 2);
        ns = n1 + n2;
        for (int i = 0; i < ns; i++) begin
            d = $urandom & 32'hFFFFFF;
            push(d, (i == n1 - 1) || (i == ns - 1), a0);
            add_pixel(d, 24);
            if (i == n1 - 1) set_gap(NEWF);
        end
        valid = 1'b0;
        set_gap(-1);
        wait_done();
        analyze("rnd");
        r0 = qat(rises, 0);
        check("rnd.nunder", unds.size(), 0);
        check("rnd.nbusyfall", bfalls.size(), 2);
        check("rnd.busyfall", qat(bfalls, 1) - r0, n1 * 24 * TB + NEWF - TB + n2 * 24 * TB + TR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
